// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - issue-bundle interface between the ALU issue stage and the EXU
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // Handshake
    logic                  out_valid;
    logic                  out_ready;

    // ALU operand bundle
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_ctl;

    // Side-band fields carried alongside the operands
    logic [4:0]            out_rd;
    logic                  out_wen;
    logic                  out_br;
    logic [2:0]            out_br_f3;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  out_illegal;

    // Producer side (issue stage)
    modport master (
        output out_valid,
        input  out_ready,
        output alu_a,
        output alu_b,
        output alu_ctl,
        output out_rd,
        output out_wen,
        output out_br,
        output out_br_f3,
        output out_imm,
        output out_pc,
        output out_illegal
    );

    // Consumer side (EXU)
    modport slave (
        input  out_valid,
        output out_ready,
        input  alu_a,
        input  alu_b,
        input  alu_ctl,
        input  out_rd,
        input  out_wen,
        input  out_br,
        input  out_br_f3,
        input  out_imm,
        input  out_pc,
        input  out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode-and-issue stage producing ALU operands; macro ALU_ISSUE_FWD_EN enables writeback forwarding
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    alu_issue_stage_if.master     iss
);

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // ALU op selects used directly by the decoder
    localparam logic [3:0] CTL_ADD    = 4'b0000;
    localparam logic [3:0] CTL_SUB    = 4'b1000;

    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Instruction fields
    logic [6:0]            w_opcode;
    logic [4:0]            w_rd;
    logic [2:0]            w_f3;
    logic [4:0]            w_rs1_idx;
    logic [4:0]            w_rs2_idx;
    logic [6:0]            w_f7;
    logic                  w_f3_is_shift;

    assign w_opcode      = in_inst[6:0];
    assign w_rd          = in_inst[11:7];
    assign w_f3          = in_inst[14:12];
    assign w_rs1_idx     = in_inst[19:15];
    assign w_rs2_idx     = in_inst[24:20];
    assign w_f7          = in_inst[31:25];
    assign w_f3_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Sign-extended immediates for every RV32I format
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_b;
    logic [DATA_WIDTH-1:0] w_imm_u;
    logic [DATA_WIDTH-1:0] w_imm_j;
    logic [DATA_WIDTH-1:0] w_shamt;

    assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u = {in_inst[31:12], 12'b0};
    assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign w_shamt = {{(DATA_WIDTH-5){1'b0}}, in_inst[24:20]};

    // Source operands, optionally bypassed from the writeback port
    logic [DATA_WIDTH-1:0] w_rs1;
    logic [DATA_WIDTH-1:0] w_rs2;

`ifdef ALU_ISSUE_FWD_EN
    // A write to x0 never forwards, so x0 always reads the regfile value.
    assign w_rs1 = (wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs1_idx)) ? wb_data : rs1_data;
    assign w_rs2 = (wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs2_idx)) ? wb_data : rs2_data;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_en, wb_rd, wb_data};
    assign w_rs1       = rs1_data;
    assign w_rs2       = rs2_data;
`endif

    // Decoded bundle for the instruction currently presented
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [3:0]            w_ctl;
    logic                  w_wen;
    logic                  w_br;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_ill;

    // Opcode decode: operand selection, op select and legality
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_ctl = CTL_ADD;
        w_wen = 1'b0;
        w_br  = 1'b0;
        w_imm = '0;
        w_ill = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a   = w_rs1;
                w_b   = w_rs2;
                w_ctl = {in_inst[30], w_f3};
                w_wen = 1'b1;
                // Only add/sub and srl/sra have an alternate funct7 form.
                if ((w_f7 != F7_ZERO) &&
                    !((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))))
                    w_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                w_a   = w_rs1;
                w_b   = w_f3_is_shift ? w_shamt : w_imm_i;
                w_imm = w_imm_i;
                // Bit 30 only selects sra; for addi etc. it is immediate data.
                w_ctl = {(w_f3 == 3'b101) ? in_inst[30] : 1'b0, w_f3};
                w_wen = 1'b1;
                if ((w_f3 == 3'b001) && (w_f7 != F7_ZERO))
                    w_ill = 1'b1;
                if ((w_f3 == 3'b101) && (w_f7 != F7_ZERO) && (w_f7 != F7_ALT))
                    w_ill = 1'b1;
            end
            OPC_LUI: begin
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_wen = 1'b1;
            end
            OPC_AUIPC: begin
                w_a   = in_pc;
                w_b   = w_imm_u;
                w_imm = w_imm_u;
                w_wen = 1'b1;
            end
            OPC_JAL: begin
                // ALU computes the link address; the target uses out_imm.
                w_a   = in_pc;
                w_b   = DATA_WIDTH'(4);
                w_imm = w_imm_j;
                w_wen = 1'b1;
            end
            OPC_JALR: begin
                w_a   = in_pc;
                w_b   = DATA_WIDTH'(4);
                w_imm = w_imm_i;
                w_wen = 1'b1;
            end
            OPC_BRANCH: begin
                // Subtract drives the EXU's eq/lt/ltu comparison flags.
                w_a   = w_rs1;
                w_b   = w_rs2;
                w_ctl = CTL_SUB;
                w_br  = 1'b1;
                w_imm = w_imm_b;
                if ((w_f3 == 3'b010) || (w_f3 == 3'b011))
                    w_ill = 1'b1;
            end
            OPC_LOAD: begin
                w_a   = w_rs1;
                w_b   = w_imm_i;
                w_imm = w_imm_i;
                w_wen = 1'b1;
            end
            OPC_STORE: begin
                w_a   = w_rs1;
                w_b   = w_imm_s;
                w_imm = w_imm_s;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
        // Illegal encodings still issue, but must not write back or branch.
        if (w_ill) begin
            w_wen = 1'b0;
            w_br  = 1'b0;
            w_ctl = CTL_ADD;
        end
        if (w_rd == 5'd0)
            w_wen = 1'b0;
    end

    // Single-entry pipeline register
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [3:0]            r_ctl;
    logic [4:0]            r_rd;
    logic                  r_wen;
    logic                  r_br;
    logic [2:0]            r_br_f3;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_ill;

    logic                  w_in_ready;
    logic                  w_load;

    assign w_in_ready = !r_valid || iss.out_ready;
    assign w_load     = in_valid && w_in_ready && !flush;

    // Pipeline register update: reset, then flush, then load, then drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ctl   <= 4'b0000;
            r_rd    <= 5'd0;
            r_wen   <= 1'b0;
            r_br    <= 1'b0;
            r_br_f3 <= 3'b000;
            r_imm   <= '0;
            r_pc    <= '0;
            r_ill   <= 1'b0;
        end else if (flush) begin
            // Data registers keep stale contents; only valid is cleared.
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_ctl   <= w_ctl;
            r_rd    <= w_rd;
            r_wen   <= w_wen;
            r_br    <= w_br;
            r_br_f3 <= w_f3;
            r_imm   <= w_imm;
            r_pc    <= in_pc;
            r_ill   <= w_ill;
        end else if (iss.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready        = w_in_ready;
    assign iss.out_valid   = r_valid;
    assign iss.alu_a       = r_a;
    assign iss.alu_b       = r_b;
    assign iss.alu_ctl     = r_ctl;
    assign iss.out_rd      = r_rd;
    assign iss.out_wen     = r_wen;
    assign iss.out_br      = r_br;
    assign iss.out_br_f3   = r_br_f3;
    assign iss.out_imm     = r_imm;
    assign iss.out_pc      = r_pc;
    assign iss.out_illegal = r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    typedef struct packed {
        logic        illegal;
        logic        wen;
        logic        br;
        logic        chk_imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[13];

    alu_issue_stage_if #(.DATA_WIDTH(32)) iss();

    alu_issue_stage #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .iss      (iss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input exp_t e);
        chk({tag, ".valid"},   32'(iss.out_valid),   32'd1);
        chk({tag, ".illegal"}, 32'(iss.out_illegal), 32'(e.illegal));
        chk({tag, ".wen"},     32'(iss.out_wen),     32'(e.wen));
        chk({tag, ".br"},      32'(iss.out_br),      32'(e.br));
        chk({tag, ".ctl"},     32'(iss.alu_ctl),     32'(e.ctl));
        chk({tag, ".pc"},      iss.out_pc,           e.pc);
        if (!e.illegal) begin
            chk({tag, ".a"}, iss.alu_a, e.a);
            chk({tag, ".b"}, iss.alu_b, e.b);
            if (e.wen)     chk({tag, ".rd"},  32'(iss.out_rd),    32'(e.rd));
            if (e.br)      chk({tag, ".f3"},  32'(iss.out_br_f3), 32'(e.f3));
            if (e.chk_imm) chk({tag, ".imm"}, iss.out_imm,        e.imm);
        end
    endtask

    function automatic exp_t mk(input logic ill, input logic wen, input logic br, input logic ci,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [3:0] ctl, input logic [4:0] rd,
                                input logic [2:0] f3);
        exp_t e;
        e = '{ill, wen, br, ci, a, b, imm, pc, ctl, rd, f3};
        return e;
    endfunction

    // Writeback bypass as seen by the instruction in the load cycle
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] data);
        logic [31:0] v;
        v = data;
`ifdef ALU_ISSUE_FWD_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == idx) v = wb_data;
`else
        if (idx == 5'd31 && 1'b0) v = wb_data;
`endif
        return v;
    endfunction

    // Reference decode from the RV32I rules, immediates by arithmetic shifts
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        op   = inst[6:0];
        f3   = inst[14:12];
        f7   = inst[31:25];
        iimm = 32'($signed(inst) >>> 20);
        simm = (iimm & 32'hFFFF_FFE0) | 32'(inst[11:7]);
        bimm = (32'($signed(inst) >>> 19) & 32'hFFFF_F000) | (32'(inst[7]) << 11)
             | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        uimm = inst & 32'hFFFF_F000;
        jimm = (32'($signed(inst) >>> 11) & 32'hFFF0_0000) | (inst & 32'h000F_F000)
             | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        e    = '0;
        e.pc = pc;
        e.rd = inst[11:7];
        e.f3 = f3;
        case (op)
            7'h33: begin
                e.a = r1; e.b = r2; e.ctl = {inst[30], f3}; e.wen = 1'b1;
                e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                e.a   = r1;
                e.b   = (f3 == 3'd1 || f3 == 3'd5) ? 32'(inst[24:20]) : iimm;
                e.ctl = {(f3 == 3'd5) && inst[30], f3};
                e.wen = 1'b1;
                e.illegal = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h37: begin e.a = 32'd0; e.b = uimm; e.wen = 1'b1; end
            7'h17: begin e.a = pc; e.b = uimm; e.wen = 1'b1; end
            7'h6f: begin e.a = pc; e.b = 32'd4; e.imm = jimm; e.chk_imm = 1'b1; e.wen = 1'b1; end
            7'h67: begin e.a = pc; e.b = 32'd4; e.imm = iimm; e.chk_imm = 1'b1; e.wen = 1'b1; end
            7'h63: begin
                e.a = r1; e.b = r2; e.ctl = 4'b1000; e.br = 1'b1; e.imm = bimm; e.chk_imm = 1'b1;
                e.illegal = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h03: begin e.a = r1; e.b = iimm; e.wen = 1'b1; end
            7'h23: begin e.a = r1; e.b = simm; end
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin
            e.wen = 1'b0; e.br = 1'b0; e.ctl = 4'b0000; e.chk_imm = 1'b0;
        end
        if (e.rd == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops[9];
        int          k;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23};
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) r[6:0] = ops[k];
        if (k < 2) begin
            case ($urandom_range(0, 2))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                default: ;
            endcase
        end
        if ($urandom_range(0, 1) == 1) r[19:15] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        in_valid      = v;
        in_inst       = inst;
        in_pc         = pc;
        rs1_data      = r1;
        rs2_data      = r2;
        iss.out_ready = ordy;
        flush         = fl;
    endtask

    initial begin
        logic        m_valid;
        logic        acc;
        exp_t        m_exp;
        exp_t        nxt;
        logic [31:0] fwd_exp;

        vecs[0]  = '{32'h40208133, 32'h100, 32'd10, 32'd3,
                     mk(0, 1, 0, 0, 32'd10, 32'd3, 32'd0, 32'h100, 4'b1000, 5'd2, 3'd0)};
        vecs[1]  = '{32'h4030d093, 32'h104, 32'h80000000, 32'd0,
                     mk(0, 1, 0, 0, 32'h80000000, 32'd3, 32'd0, 32'h104, 4'b1101, 5'd1, 3'd5)};
        vecs[2]  = '{32'h4230d093, 32'h108, 32'h80000000, 32'd0,
                     mk(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'h108, 4'b0000, 5'd1, 3'd5)};
        vecs[3]  = '{32'h00208463, 32'h200, 32'd5, 32'd5,
                     mk(0, 0, 1, 1, 32'd5, 32'd5, 32'd8, 32'h200, 4'b1000, 5'd8, 3'd0)};
        vecs[4]  = '{32'hfff00293, 32'h204, 32'h1234, 32'd0,
                     mk(0, 1, 0, 0, 32'h1234, 32'hffffffff, 32'd0, 32'h204, 4'b0000, 5'd5, 3'd0)};
        vecs[5]  = '{32'h123453b7, 32'h208, 32'd0, 32'd0,
                     mk(0, 1, 0, 0, 32'd0, 32'h12345000, 32'd0, 32'h208, 4'b0000, 5'd7, 3'd0)};
        vecs[6]  = '{32'h00001017, 32'h300, 32'd0, 32'd0,
                     mk(0, 0, 0, 0, 32'h300, 32'h1000, 32'd0, 32'h300, 4'b0000, 5'd0, 3'd0)};
        vecs[7]  = '{32'h010000ef, 32'h400, 32'd0, 32'd0,
                     mk(0, 1, 0, 1, 32'h400, 32'd4, 32'd16, 32'h400, 4'b0000, 5'd1, 3'd0)};
        vecs[8]  = '{32'h0020a223, 32'h404, 32'h1000, 32'd7,
                     mk(0, 0, 0, 0, 32'h1000, 32'd4, 32'd0, 32'h404, 4'b0000, 5'd4, 3'd2)};
        vecs[9]  = '{32'h0000007f, 32'h408, 32'd0, 32'd0,
                     mk(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'h408, 4'b0000, 5'd0, 3'd0)};
        vecs[10] = '{32'h40209133, 32'h40c, 32'd1, 32'd2,
                     mk(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'h40c, 4'b0000, 5'd2, 3'd1)};
        vecs[11] = '{32'h0020a463, 32'h410, 32'd1, 32'd2,
                     mk(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'h410, 4'b0000, 5'd8, 3'd2)};
        vecs[12] = '{32'hfe209ee3, 32'h414, 32'd9, 32'd4,
                     mk(0, 0, 1, 1, 32'd9, 32'd4, 32'hfffffffc, 32'h414, 4'b1000, 5'd29, 3'd1)};

        // Reset
        rst_n = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        drive(1'b1, 32'h40208133, 32'h0, 32'd1, 32'd1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(iss.out_valid), 32'd0);
        chk("reset.alu_ctl",   32'(iss.alu_ctl),   32'd0);
        chk("reset.alu_a",     iss.alu_a,          32'd0);
        chk("reset.out_pc",    iss.out_pc,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Table of single-instruction vectors, issued back to back
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk_bundle($sformatf("vec%0d", i), vecs[i].e);
        end

        // Backpressure: beq held while addi waits upstream
        @(negedge clk);
        drive(1'b1, vecs[3].inst, vecs[3].pc, vecs[3].rs1, vecs[3].rs2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_bundle("bp.load", vecs[3].e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[4].inst, vecs[4].pc, vecs[4].rs1, vecs[4].rs2, 1'b0, 1'b0);
            #1;
            chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk_bundle($sformatf("bp.hold%0d", i), vecs[3].e);
        end
        @(negedge clk);
        iss.out_ready = 1'b1;
        #1;
        chk("bp.in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_bundle("bp.addi", vecs[4].e);

        // Flush with a held bundle and an incoming instruction
        @(negedge clk);
        drive(1'b1, vecs[5].inst, vecs[5].pc, vecs[5].rs1, vecs[5].rs2, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("flush.out_valid", 32'(iss.out_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("flush.dropped", 32'(iss.out_valid), 32'd0);

        // Writeback forwarding (or its absence) on add x3,x1,x2
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h002081b3, 32'h500, 32'd5, 32'd7, 1'b1, 1'b0);
            wb_en   = 1'b1;
            wb_data = 32'd99;
            wb_rd   = (i == 0) ? 5'd1 : (i == 1) ? 5'd0 : 5'd2;
            @(posedge clk);
            #1;
            fwd_exp = 32'd5;
`ifdef ALU_ISSUE_FWD_EN
            if (i == 0) fwd_exp = 32'd99;
`endif
            chk($sformatf("fwd%0d.alu_a", i), iss.alu_a, fwd_exp);
            fwd_exp = 32'd7;
`ifdef ALU_ISSUE_FWD_EN
            if (i == 2) fwd_exp = 32'd99;
`endif
            chk($sformatf("fwd%0d.alu_b", i), iss.alu_b, fwd_exp);
        end

        // Randomised traffic against the reference model
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        wb_en = 1'b0;
        @(posedge clk);
        m_valid = 1'b0;
        m_exp   = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_rd   = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            #1;
            chk("rnd.in_ready", 32'(in_ready), 32'(!m_valid || iss.out_ready));
            acc = in_valid && (!m_valid || iss.out_ready) && !flush;
            nxt = model(in_inst, in_pc, fwd(in_inst[19:15], rs1_data), fwd(in_inst[24:20], rs2_data));
            @(posedge clk);
            #1;
            if (flush)              m_valid = 1'b0;
            else if (acc)           begin m_valid = 1'b1; m_exp = nxt; end
            else if (iss.out_ready) m_valid = 1'b0;
            chk("rnd.out_valid", 32'(iss.out_valid), 32'(m_valid));
            if (m_valid) chk_bundle("rnd", m_exp);
        end

        // Reset while a bundle is held
        @(negedge clk);
        drive(1'b1, vecs[0].inst, 32'h100, 32'd10, 32'd3, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset2.out_valid", 32'(iss.out_valid), 32'd0);
        chk("reset2.alu_ctl",   32'(iss.alu_ctl),   32'd0);
        chk("reset2.alu_b",     iss.alu_b,          32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-and-issue stage that produces the `a`, `b` and `ctl` operand bundle consumed by the core's ALU. It is the producer end of the ALU interface.
- Takes a fetched RV32I instruction plus register-file read data, decodes it, and registers the ALU operands and side-band fields into a single-entry pipeline register.
- Uses valid/ready handshakes on both sides and supports flush.
- Sits between IFU/regfile read and EXU.

Parameters:
- DATA_WIDTH, 32, operand/PC width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  DATA_WIDTH  instruction PC.
- rs1_data  in  DATA_WIDTH  regfile read data for inst[19:15].
- rs2_data  in  DATA_WIDTH  regfile read data for inst[24:20].
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  issue bundle valid.
- out_ready  in  1  EXU accepts the bundle.
- alu_a  out  DATA_WIDTH  ALU operand a.
- alu_b  out  DATA_WIDTH  ALU operand b.
- alu_ctl  out  4  ALU op select.
- out_rd  out  5  destination register.
- out_wen  out  1  register writeback enable.
- out_br  out  1  conditional branch; EXU uses the ALU eq/lt/ltu flags.
- out_br_f3  out  3  branch funct3.
- out_imm  out  DATA_WIDTH  decoded immediate, used for branch/jump target.
- out_pc  out  DATA_WIDTH  registered PC.
- out_illegal  out  1  illegal or unsupported encoding.
- wb_en  in  1  writeback-forward enable (see Optional Feature).
- wb_rd  in  5  writeback-forward destination register.
- wb_data  in  DATA_WIDTH  writeback-forward data.

Behaviour:
- Interface: one clock `clk`; `rst_n` is synchronous, active-low.
- Reset: while rst_n=0 at a rising edge, out_valid=0 and all registered outputs are 0 (alu_ctl=4'b0000).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load occurs when in_valid && in_ready && !flush. Decode results are registered and out_valid=1 next cycle.
  - If out_ready && out_valid with no load, out_valid goes to 0.
  - Simultaneous accept-out and load-in gives back-to-back issue with no bubble.
- Stall: while out_valid && !out_ready, every output holds stable.
- Flush: has highest priority after reset. Next cycle out_valid=0, and an instruction presented in the same cycle is dropped. Data registers may keep stale values.
- Latency: 1 cycle from accepted input to out_valid.
- alu_ctl encoding (= {sub/arith bit, funct3}):
  - add 0000, sub 1000, sll 0001, slt 0010, sltu 0011.
  - xor 0100, srl 0101, sra 1101, or 0110, and 0111.
- Decode by opcode (imm is sign-extended per RV32I format):
  - OP (0110011): a=rs1, b=rs2, ctl={inst[30],f3}, wen=1. funct7 other than 0000000, or 0100000 with f3 not in {000,101}, is illegal.
  - OP-IMM (0010011): a=rs1, b=I-imm, ctl={f3==101 ? inst[30] : 0, f3}. For slli/srli/srai, b=shamt zero-extended. For f3=001, inst[31:25]≠0 is illegal. For f3=101, inst[31:25] not in {0000000, 0100000} is illegal.
  - LUI: a=0, b=U-imm, ctl=0000.
  - AUIPC: a=pc, b=U-imm, ctl=0000.
  - JAL: a=pc, b=4, ctl=0000, imm=J-imm.
  - JALR: a=pc, b=4, ctl=0000, imm=I-imm. EXU forms target rs1+imm, with rs1 carried… out_imm only.
  - BRANCH: a=rs1, b=rs2, ctl=1000, br=1, wen=0, imm=B-imm. f3 010 and 011 are illegal.
  - LOAD: a=rs1, b=I-imm, ctl=0000, wen=1.
  - STORE: a=rs1, b=S-imm, ctl=0000, wen=0.
  - Any other opcode: illegal.
- Illegal instruction: out_illegal=1, wen=0, br=0, ctl=0000, and the instruction still issues with out_valid=1.
- rd=x0 forces out_wen=0.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: when wb_en && wb_rd≠0 && wb_rd==rs1, rs1_data is replaced by wb_data before operand selection. The same rule applies to rs2. The bypass is combinational in the load cycle.
- Undefined: the wb_* ports remain present but are ignored, and the regfile data is used directly.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> out_valid=0, alu_ctl=0000, in_ready=1.
- sub: inst=0x40208133 (sub x2,x1,x2), rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=3, ctl=1000, rd=2, wen=1.
- srai: inst=0x4030d093 (srai x1,x1,3), rs1=0x80000000 -> ctl=1101, alu_b=3. Same encoding with inst[31:25]=0100001 -> out_illegal=1, wen=0.
- Backpressure: issue beq (0x00208463) with out_ready=0 for 3 cycles while in_valid=1 with addi -> in_ready=0, outputs stable (ctl=1000, br=1, imm=8). Raise out_ready -> addi issues the next cycle with no bubble.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the incoming instruction is never issued.
- Forwarding (ALU_ISSUE_FWD_EN defined): add x3,x1,x2, rs1_data=5, wb_en=1, wb_rd=1, wb_data=99 -> alu_a=99. With wb_rd=0 -> alu_a=5.
